// File: rtl/fila_busca.sv
// fila_busca: instruction prefetch queue feeding the core with address-tagged words
module fila_busca #(
  parameter int AW = 8,
  parameter int IW = 8,
  parameter int DEPTH = 4
) (
  input  logic                       Clock,
  input  logic                       reset,
  output logic [AW-1:0]              MemEndereco,
  output logic                       MemLer,
  input  logic [IW-1:0]              MemInstrucao,
  input  logic                       Desvio,
  input  logic [AW-1:0]              DesvioEndereco,
  output logic [IW-1:0]              Instrucao,
  output logic [AW-1:0]              InstrucaoPC,
  output logic                       Valida,
  input  logic                       Consome,
  output logic [$clog2(DEPTH+1)-1:0] Ocupacao
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] fetch_pc, pend_pc;
  logic pendente, pop, push, issue;
  logic [IW+AW-1:0] fifo [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0] demand;
  always_comb begin
    Valida = !reset && count != '0;
    {Instrucao, InstrucaoPC} = Valida ? fifo[rd_ptr] : '0;
    Ocupacao = reset ? '0 : count;
    pop = Valida && Consome && !Desvio;
    push = pendente && !Desvio;
    demand = {1'b0, count} + (CW+1)'(pendente) - (CW+1)'(pop);
    issue = !reset && !Desvio && demand < (CW+1)'(DEPTH);
    MemLer = issue;
    MemEndereco = reset ? '0 : fetch_pc;
  end
  always_ff @(posedge Clock) begin
    if (reset || Desvio) begin
      fetch_pc <= reset ? '0 : DesvioEndereco;
      pend_pc <= reset ? '0 : pend_pc;
      pendente <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      pendente <= issue;
      if (issue) begin
        pend_pc <= fetch_pc;
        fetch_pc <= fetch_pc + AW'(1);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge Clock)
    if (push && !reset) fifo[wr_ptr] <= {MemInstrucao, pend_pc};
endmodule

// File: tb/tb_fila_busca.sv
// tb_fila_busca: directed stimulus with an issue-order scoreboard for fila_busca
module tb_fila_busca;
  logic       Clock = 1'b0;
  logic       reset, MemLer, Desvio, Valida, Consome;
  logic [7:0] MemEndereco, MemInstrucao, DesvioEndereco, Instrucao, InstrucaoPC, e;
  logic [2:0] Ocupacao;
  int errors = 0, checks = 0, n = 0, fv = -1, nl = 0;
  logic [7:0] sb [$];
  logic [7:0] exp_pc;

  fila_busca dut (
    .Clock(Clock), .reset(reset), .MemEndereco(MemEndereco), .MemLer(MemLer),
    .MemInstrucao(MemInstrucao), .Desvio(Desvio), .DesvioEndereco(DesvioEndereco),
    .Instrucao(Instrucao), .InstrucaoPC(InstrucaoPC), .Valida(Valida),
    .Consome(Consome), .Ocupacao(Ocupacao)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock)
    if (MemLer) MemInstrucao <= MemEndereco ^ 8'hA5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(posedge Clock) begin
    if (reset || Desvio) sb.delete();
    else begin
      if (Valida && Consome) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_underflow: observed pc=%0h expected=none", InstrucaoPC);
        end else begin
          exp_pc = sb.pop_front();
          chk("sb_pc", {24'b0, InstrucaoPC}, {24'b0, exp_pc});
          chk("sb_instr", {24'b0, Instrucao}, {24'b0, exp_pc ^ 8'hA5});
        end
      end
      if (MemLer) sb.push_back(MemEndereco);
    end
  end

  initial begin
    reset = 1'b1; Desvio = 1'b0; Consome = 1'b0; DesvioEndereco = 8'h00;
    repeat (2) @(negedge Clock);
    #1;
    chk("rst_memler", {31'b0, MemLer}, 0);
    chk("rst_addr", {24'b0, MemEndereco}, 0);
    chk("rst_valida", {31'b0, Valida}, 0);
    chk("rst_instr", {24'b0, Instrucao}, 0);
    chk("rst_pc", {24'b0, InstrucaoPC}, 0);
    chk("rst_ocup", {29'b0, Ocupacao}, 0);
    @(negedge Clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (MemLer) begin
        chk("fill_addr", {24'b0, MemEndereco}, n);
        n++;
      end
      if (Valida && fv < 0) fv = i;
      @(negedge Clock);
    end
    chk("fill_issues", n, 4);
    chk("valida_rise", fv, 2);
    #1;
    chk("fill_ocup", {29'b0, Ocupacao}, 4);
    chk("fill_instr", {24'b0, Instrucao}, 32'hA5);
    chk("fill_pc", {24'b0, InstrucaoPC}, 0);
    chk("fill_memler", {31'b0, MemLer}, 0);
    Consome = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("stream_valid", {31'b0, Valida}, 1);
      chk("stream_pc", {24'b0, InstrucaoPC}, i);
      @(negedge Clock);
    end
    Desvio = 1'b1; DesvioEndereco = 8'h40;
    #1 chk("desvio_memler", {31'b0, MemLer}, 0);
    @(negedge Clock);
    Desvio = 1'b0;
    #1;
    chk("redir_valida", {31'b0, Valida}, 0);
    chk("redir_addr", {24'b0, MemEndereco}, 32'h40);
    chk("redir_memler", {31'b0, MemLer}, 1);
    @(negedge Clock);
    #1 chk("redir_gap", {31'b0, Valida}, 0);
    @(negedge Clock);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("redir_valid", {31'b0, Valida}, 1);
      chk("redir_pc", {24'b0, InstrucaoPC}, 32'h40 + i);
      @(negedge Clock);
    end
    Desvio = 1'b1; DesvioEndereco = 8'hFE;
    @(negedge Clock);
    Desvio = 1'b0;
    repeat (2) @(negedge Clock);
    for (int i = 0; i < 4; i++) begin
      e = 8'hFE + 8'(i);
      #1;
      chk("wrap_valid", {31'b0, Valida}, 1);
      chk("wrap_pc", {24'b0, InstrucaoPC}, {24'b0, e});
      @(negedge Clock);
    end
    Consome = 1'b0;
    repeat (6) @(negedge Clock);
    #1;
    chk("full_ocup", {29'b0, Ocupacao}, 4);
    chk("full_memler", {31'b0, MemLer}, 0);
    chk("full_pc", {24'b0, InstrucaoPC}, 32'h02);
    Consome = 1'b1;
    #1 nl += int'(MemLer);
    @(negedge Clock);
    Consome = 1'b0;
    #1;
    nl += int'(MemLer);
    chk("pp_ocup3", {29'b0, Ocupacao}, 3);
    chk("pp_pc", {24'b0, InstrucaoPC}, 32'h03);
    @(negedge Clock);
    #1;
    nl += int'(MemLer);
    chk("pp_ocup4", {29'b0, Ocupacao}, 4);
    @(negedge Clock);
    #1 nl += int'(MemLer);
    chk("pp_pulses", nl, 1);
    Desvio = 1'b1; DesvioEndereco = 8'h10;
    @(negedge Clock);
    Desvio = 1'b0;
    repeat (3) @(negedge Clock);
    #1 chk("mid_ocup2", {29'b0, Ocupacao}, 2);
    reset = 1'b1;
    #1;
    chk("mid_rst_memler", {31'b0, MemLer}, 0);
    chk("mid_rst_addr", {24'b0, MemEndereco}, 0);
    chk("mid_rst_valida", {31'b0, Valida}, 0);
    chk("mid_rst_instr", {24'b0, Instrucao}, 0);
    chk("mid_rst_pc", {24'b0, InstrucaoPC}, 0);
    chk("mid_rst_ocup", {29'b0, Ocupacao}, 0);
    @(negedge Clock);
    reset = 1'b0;
    #1;
    chk("post_valida", {31'b0, Valida}, 0);
    chk("post_ocup", {29'b0, Ocupacao}, 0);
    chk("post_instr", {24'b0, Instrucao}, 0);
    chk("post_pc", {24'b0, InstrucaoPC}, 0);
    chk("post_addr", {24'b0, MemEndereco}, 0);
    repeat (6) @(negedge Clock);
    #1;
    chk("refill_ocup", {29'b0, Ocupacao}, 4);
    chk("refill_pc", {24'b0, InstrucaoPC}, 0);
    chk("refill_instr", {24'b0, Instrucao}, 32'hA5);
    Consome = 1'b1;
    repeat (8) @(negedge Clock);
    Consome = 1'b0;
    @(negedge Clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
